// File: rtl/vga_sync_gen_if.sv
// ============================================================================
// vga_sync_gen_if : raster timing bundle from the sync generator to its sinks
// Revision 1.0
// ============================================================================
`default_nettype none

interface vga_sync_gen_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       line_tick;
  logic       frame_tick;

  modport master (
    output hsync, vsync, video_on, pixel_x, pixel_y, line_tick, frame_tick
  );

  modport slave (
    input  hsync, vsync, video_on, pixel_x, pixel_y, line_tick, frame_tick
  );
endinterface

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// vga_sync_gen : VGA raster timing generator (counters, syncs, strobes)
// Revision 1.0
// ============================================================================
`default_nettype none

module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  wire logic        clk_25mhz,
  input  wire logic        rst,
  vga_sync_gen_if.master   vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  C_H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  C_V_MAX    = 10'(V_TOTAL - 1);
  // Decode bounds are 11 bits so a sync end equal to 1024 still compares correctly
  localparam logic [10:0] C_H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] C_HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] C_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] C_V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] C_VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] C_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_video_on;
  logic        r_line_tick;
  logic        r_frame_tick;

  logic        w_x_wrap;
  logic [9:0]  w_x_nxt;
  logic [9:0]  w_y_nxt;
  logic [10:0] w_x_ext;
  logic [10:0] w_y_ext;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_video;
  logic        w_line;
  logic        w_frame;

  // Outputs are decoded from the next counter values so they align with pixel_x/y
  always_comb begin
    w_x_wrap = (r_x == C_H_MAX);
    w_x_nxt  = w_x_wrap ? 10'd0 : r_x + 10'd1;
    w_y_nxt  = r_y;
    if (w_x_wrap) begin
      w_y_nxt = (r_y == C_V_MAX) ? 10'd0 : r_y + 10'd1;
    end
    w_x_ext  = {1'b0, w_x_nxt};
    w_y_ext  = {1'b0, w_y_nxt};
    w_hs_act = (w_x_ext >= C_HS_BEG) && (w_x_ext < C_HS_END);
    w_vs_act = (w_y_ext >= C_VS_BEG) && (w_y_ext < C_VS_END);
    w_video  = (w_x_ext < C_H_ACT) && (w_y_ext < C_V_ACT);
    w_line   = (w_x_nxt == C_H_MAX);
    w_frame  = w_line && (w_y_nxt == C_V_MAX);
  end

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      r_x          <= C_H_MAX;
      r_y          <= C_V_MAX;
      r_hsync      <= ~SYNC_POL;
      r_vsync      <= ~SYNC_POL;
      r_video_on   <= 1'b0;
      r_line_tick  <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_hsync      <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync      <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_video_on   <= w_video;
      r_line_tick  <= w_line;
      r_frame_tick <= w_frame;
    end
  end

  assign vga.pixel_x    = r_x;
  assign vga.pixel_y    = r_y;
  assign vga.hsync      = r_hsync;
  assign vga.vsync      = r_vsync;
  assign vga.video_on   = r_video_on;
  assign vga.line_tick  = r_line_tick;
  assign vga.frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// tb_vga_sync_gen : checks default 640x480 timing and a shrunk active-high variant
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

  // Shrunk timing for instance B so whole frames fit in a short run
  localparam int B_HA = 16, B_HFP = 4, B_HS = 6, B_HBP = 6;
  localparam int B_VA = 12, B_VFP = 2, B_VS = 2, B_VBP = 4;
  localparam int B_FRAME = (B_HA + B_HFP + B_HS + B_HBP) * (B_VA + B_VFP + B_VS + B_VBP);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n;
  int   checks = 0;
  int   errors = 0;

  vga_sync_gen_if vif_a();
  vga_sync_gen_if vif_b();

  vga_sync_gen u_dut_a (
    .clk_25mhz (clk),
    .rst       (rst),
    .vga       (vif_a)
  );

  vga_sync_gen #(
    .H_ACTIVE (B_HA), .H_FP (B_HFP), .H_SYNC (B_HS), .H_BP (B_HBP),
    .V_ACTIVE (B_VA), .V_FP (B_VFP), .V_SYNC (B_VS), .V_BP (B_VBP),
    .SYNC_POL (1'b1)
  ) u_dut_b (
    .clk_25mhz (clk),
    .rst       (rst),
    .vga       (vif_b)
  );

  always #20 clk = ~clk;

  // Number of rising edges seen since reset was last released
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog run did not finish checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Expected {hsync,vsync,video_on,line_tick,frame_tick,x,y} after k edges out of reset
  function automatic logic [24:0] model(input int k, input int ha, input int hfp, input int hs,
                                        input int hbp, input int va, input int vfp, input int vs,
                                        input int vbp, input bit pol);
    int ht, vt, idx, x, y;
    bit hsa, vsa, vid, lt, ft;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    if (k == 0) return {~pol, ~pol, 3'b000, 10'(ht - 1), 10'(vt - 1)};
    idx = k - 1;
    x   = idx % ht;
    y   = (idx / ht) % vt;
    hsa = (x >= ha + hfp) && (x < ha + hfp + hs);
    vsa = (y >= va + vfp) && (y < va + vfp + vs);
    vid = (x < ha) && (y < va);
    lt  = (x == ht - 1);
    ft  = lt && (y == vt - 1);
    return {hsa ? pol : ~pol, vsa ? pol : ~pol, vid, lt, ft, 10'(x), 10'(y)};
  endfunction

  function automatic logic [24:0] exp_a(input int k);
    return model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
  endfunction

  function automatic logic [24:0] exp_b(input int k);
    return model(k, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, 1'b1);
  endfunction

  function automatic logic [24:0] obs_a();
    return {vif_a.hsync, vif_a.vsync, vif_a.video_on, vif_a.line_tick, vif_a.frame_tick,
            vif_a.pixel_x, vif_a.pixel_y};
  endfunction

  function automatic logic [24:0] obs_b();
    return {vif_b.hsync, vif_b.vsync, vif_b.video_on, vif_b.line_tick, vif_b.frame_tick,
            vif_b.pixel_x, vif_b.pixel_y};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a() !== exp_a(0)) begin
        errors++;
        $display("FAIL reset_a got %h exp %h", obs_a(), exp_a(0));
      end
      checks++;
      if (obs_b() !== exp_b(0)) begin
        errors++;
        $display("FAIL reset_b got %h exp %h", obs_b(), exp_b(0));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_first_lines();
    for (int i = 0; i < 2 * 800 + 20; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a() !== exp_a(n)) begin
        errors++;
        if (errors < 30) $display("FAIL lines_a n=%0d got %h exp %h", n, obs_a(), exp_a(n));
      end
      checks++;
      if (obs_b() !== exp_b(n)) begin
        errors++;
        if (errors < 30) $display("FAIL lines_b n=%0d got %h exp %h", n, obs_b(), exp_b(n));
      end
      // Pinned landmarks of the default 800x525 timing
      if (n == 1) begin
        checks++;
        if ({vif_a.pixel_x, vif_a.pixel_y, vif_a.video_on} !== {10'd0, 10'd0, 1'b1}) begin
          errors++;
          $display("FAIL first_pixel got x=%0d y=%0d vid=%b exp 0 0 1",
                   vif_a.pixel_x, vif_a.pixel_y, vif_a.video_on);
        end
      end
      if (n == 657) begin
        checks++;
        if ({vif_a.pixel_x, vif_a.hsync} !== {10'd656, 1'b0}) begin
          errors++;
          $display("FAIL hsync_start got x=%0d hs=%b exp 656 0", vif_a.pixel_x, vif_a.hsync);
        end
      end
      if (n == 801) begin
        checks++;
        if ({vif_a.pixel_x, vif_a.pixel_y} !== {10'd0, 10'd1}) begin
          errors++;
          $display("FAIL line_wrap got x=%0d y=%0d exp 0 1", vif_a.pixel_x, vif_a.pixel_y);
        end
      end
    end
  endtask

  task automatic test_frames();
    int last_ft = -1;
    for (int i = 0; i < 3 * B_FRAME + 50; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a() !== exp_a(n)) begin
        errors++;
        if (errors < 30) $display("FAIL frames_a n=%0d got %h exp %h", n, obs_a(), exp_a(n));
      end
      checks++;
      if (obs_b() !== exp_b(n)) begin
        errors++;
        if (errors < 30) $display("FAIL frames_b n=%0d got %h exp %h", n, obs_b(), exp_b(n));
      end
      if (vif_b.frame_tick === 1'b1) begin
        if (last_ft >= 0) begin
          checks++;
          if (n - last_ft != B_FRAME) begin
            errors++;
            $display("FAIL frame_period got %0d exp %0d", n - last_ft, B_FRAME);
          end
        end
        last_ft = n;
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int r = 0; r < 6; r++) begin
      int run_len;
      run_len = $urandom_range(1500, 40);
      for (int i = 0; i < run_len; i++) begin
        @(negedge clk);
        checks++;
        if (obs_a() !== exp_a(n)) begin
          errors++;
          if (errors < 30) $display("FAIL run_a n=%0d got %h exp %h", n, obs_a(), exp_a(n));
        end
        checks++;
        if (obs_b() !== exp_b(n)) begin
          errors++;
          if (errors < 30) $display("FAIL run_b n=%0d got %h exp %h", n, obs_b(), exp_b(n));
        end
      end
      // Assert reset between edges; outputs must change without a clock
      #($urandom_range(15, 2));
      rst = 1'b1;
      #1;
      checks++;
      if (obs_a() !== exp_a(0)) begin
        errors++;
        $display("FAIL async_rst_a got %h exp %h", obs_a(), exp_a(0));
      end
      checks++;
      if (obs_b() !== exp_b(0)) begin
        errors++;
        $display("FAIL async_rst_b got %h exp %h", obs_b(), exp_b(0));
      end
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        checks++;
        if (obs_a() !== exp_a(0)) begin
          errors++;
          $display("FAIL hold_rst_a got %h exp %h", obs_a(), exp_a(0));
        end
        checks++;
        if (obs_b() !== exp_b(0)) begin
          errors++;
          $display("FAIL hold_rst_b got %h exp %h", obs_b(), exp_b(0));
        end
      end
      rst = 1'b0;
    end
    for (int i = 0; i < 2 * B_FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a() !== exp_a(n)) begin
        errors++;
        if (errors < 30) $display("FAIL tail_a n=%0d got %h exp %h", n, obs_a(), exp_a(n));
      end
      checks++;
      if (obs_b() !== exp_b(n)) begin
        errors++;
        if (errors < 30) $display("FAIL tail_b n=%0d got %h exp %h", n, obs_b(), exp_b(n));
      end
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_first_lines();
    test_frames();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator for the VGA output path, clocked by the 25 MHz pixel clock from the clock divider.
- Produces horizontal and vertical sync, an active-video qualifier, the current pixel coordinates, and line and frame strobes.
- Consumed downstream by the pixel/sprite renderer and by game logic, which uses frame_tick for per-frame updates.
- Default timing is 640x480 at 60 Hz: 800 x 525 total.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clk_25mhz  in  1  pixel clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
hsync  out  1  horizontal sync, level SYNC_POL when asserted
vsync  out  1  vertical sync, level SYNC_POL when asserted
video_on  out  1  high when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
pixel_y  out  10  current vertical count, 0..V_TOTAL-1
line_tick  out  1  one-cycle pulse while pixel_x == H_TOTAL-1
frame_tick  out  1  one-cycle pulse while pixel_x == H_TOTAL-1 and pixel_y == V_TOTAL-1

Behaviour:
- Interface: one clock (clk_25mhz); reset rst is asynchronous and active-high.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both totals must be at most 1024.
- Reset (async, immediate):
  - pixel_x = H_TOTAL-1, pixel_y = V_TOTAL-1
  - hsync = vsync = ~SYNC_POL
  - video_on = 0, line_tick = 0, frame_tick = 0
  - The first rising edge after rst deasserts therefore lands on (0,0) with video_on = 1.
- Horizontal counter: increments every cycle. At H_TOTAL-1 it wraps to 0 on the next edge.
- Vertical counter: increments only on the edge where pixel_x wraps. At V_TOTAL-1 (with the pixel_x wrap) it wraps to 0. pixel_x and pixel_y wrap on the same edge at end of frame.
- All outputs are registered, with no combinational path to the ports. hsync, vsync, video_on and the ticks are decoded from the next-state counter values. Every output therefore describes the same pixel as pixel_x/pixel_y in the same cycle (zero relative skew).
- hsync is asserted iff H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync is asserted iff V_ACTIVE+V_FP <= pixel_y < V_ACTIVE+V_FP+V_SYNC (490..491). vsync spans whole lines: it changes only when pixel_x = 0.
- video_on is 0 whenever either counter is outside the active region, including during reset.
- line_tick is high for exactly 1 cycle per line, at pixel_x = 799. frame_tick is high for 1 cycle per frame and coincides with the last line_tick of the frame.
- Reset mid-frame: all outputs return to their reset values asynchronously. Timing restarts cleanly at (0,0) on the first edge after release, with no partial sync pulse or stray tick.
- Counter arithmetic is unsigned 10-bit. Counters never exceed their total minus 1.

Test Plan:
- Reset held 5 cycles -> pixel_x=799, pixel_y=524, hsync=vsync=1, video_on=0, ticks=0. First edge after release -> (0,0), video_on=1.
- Free-run line 0 -> video_on falls at pixel_x=640. hsync goes low at pixel_x=656 (edge 657 after release), high at 752. line_tick high only at pixel_x=799.
- Line wrap -> at edge 801, pixel_x=0 and pixel_y=1. pixel_y stays constant for exactly 800 cycles.
- Vertical sync -> vsync low from edge 392001 (pixel_y=490, pixel_x=0) for exactly 1600 cycles. video_on=0 for all of lines 480..524.
- Frame wrap -> frame_tick=1 only at edge 420000 (799,524). Edge 420001 -> (0,0). The next frame_tick comes exactly 420000 cycles later.
- Reset asserted at (300,200), mid-line, for 3 cycles -> outputs return to reset values without waiting for a clock edge. After release, (0,0) on the first edge, and hsync first asserts 657 edges later.
